// File: rtl/uart_tx_frame_controller_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_controller_pkg
//   Shared definitions for the UART transmit frame controller:
//   - parity mode encodings used by the PARITY_MODE parameter
//   - framing FSM state type
//   - parity helper shared by anything that latches a word for transmission
// ----------------------------------------------------------------------------
package uart_tx_frame_controller_pkg;

    // Parity mode encodings.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest word the framer accepts; the parity helper works at this width
    // and narrower words are zero-extended, which does not change the XOR.
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        S_TXF_IDLE,
        S_TXF_START,
        S_TXF_DATA,
        S_TXF_PARITY,
        S_TXF_STOP
    } tx_frame_state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input int                        mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_controller_if.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_controller_if
//   Host-side write port and status of the UART transmit frame controller.
//   Signals:
//     Write_en    host -> ctrl  write strobe, sampled every clock edge
//     Write_data  host -> ctrl  word to queue
//     Full        ctrl -> host  FIFO holds FIFO_DEPTH words
//     Empty       ctrl -> host  FIFO empty and no frame in progress
//     Overflow    ctrl -> host  one-cycle pulse: write dropped because Full
//     Frame_done  ctrl -> host  one-cycle pulse on the tick ending the last stop bit
//   Modports: master = host, slave = controller.
// ----------------------------------------------------------------------------
interface uart_tx_frame_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Write_en;
    logic [DATA_WIDTH-1:0] Write_data;
    logic                  Full;
    logic                  Empty;
    logic                  Overflow;
    logic                  Frame_done;

    modport master (
        output Write_en, Write_data,
        input  Full, Empty, Overflow, Frame_done
    );

    modport slave (
        input  Write_en, Write_data,
        output Full, Empty, Overflow, Frame_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO holding words waiting to be framed.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push, din    write request and data (ignored while full)
//     pop          read request (ignored while empty)
//     dout         word at the head of the FIFO (combinational read)
//     full, empty  occupancy flags, derived from the registered count
//   Simultaneous push and pop keep the count unchanged; a pushed word is
//   visible at dout from the cycle after the push.
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointers wrap by plain overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_frame_controller.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_controller
//   UART transmitter: queues host words in a small FIFO and serialises each
//   as start bit, DATA_WIDTH data bits LSB first, optional parity, then
//   STOP_BITS stop bits. Bit timing comes from TX_clock_enable; back-to-back
//   frames leave no idle bit between them.
//   Ports:
//     Clock            system clock
//     Resetn           asynchronous active-low reset
//     TX_clock_enable  one-cycle baud tick; framing advances only when high
//     host             write port and status (slave modport)
//     UART_TX_O        registered serial line, idle high
// ----------------------------------------------------------------------------
module uart_tx_frame_controller
    import uart_tx_frame_controller_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          TX_clock_enable,
    uart_tx_frame_controller_if.slave     host,
    output logic                          UART_TX_O
);
    localparam int              BCW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]  BIT_LAST  = BCW'(DATA_WIDTH);
    localparam logic [1:0]      STOP_LAST = 2'(STOP_BITS);

    tx_frame_state_t       state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_count_q, bit_count_d;
    logic [1:0]            stop_count_q, stop_count_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  start_frame, frame_done;

    // Full is the pre-edge flag: a pop in the same cycle does not rescue a
    // write that already sees Full.
    assign fifo_push       = host.Write_en && !fifo_full;
    assign fifo_pop        = start_frame;

    assign host.Full       = fifo_full;
    assign host.Overflow   = host.Write_en && fifo_full;
    assign host.Empty      = fifo_empty && (state_q == S_TXF_IDLE);
    assign host.Frame_done = frame_done;
    assign UART_TX_O       = tx_q;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Resetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (host.Write_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The line value driven on a tick is the bit for the period that follows
    // it, so each state drives the *next* bit of the frame.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_count_d  = bit_count_q;
        stop_count_d = stop_count_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        start_frame  = 1'b0;
        frame_done   = 1'b0;

        if (TX_clock_enable) begin
            case (state_q)
                S_TXF_IDLE: begin
                    if (!fifo_empty) start_frame = 1'b1;
                    else             tx_d        = 1'b1;
                end
                S_TXF_START: begin
                    tx_d        = shift_q[0];
                    shift_d     = shift_q >> 1;
                    bit_count_d = BCW'(1);
                    state_d     = S_TXF_DATA;
                end
                S_TXF_DATA: begin
                    if (bit_count_q < BIT_LAST) begin
                        tx_d        = shift_q[0];
                        shift_d     = shift_q >> 1;
                        bit_count_d = bit_count_q + BCW'(1);
                    end else if (PARITY_MODE != PARITY_NONE) begin
                        tx_d    = parity_q;
                        state_d = S_TXF_PARITY;
                    end else begin
                        // First stop period starts here.
                        tx_d         = 1'b1;
                        stop_count_d = 2'd1;
                        state_d      = S_TXF_STOP;
                    end
                end
                S_TXF_PARITY: begin
                    tx_d         = 1'b1;
                    stop_count_d = 2'd1;
                    state_d      = S_TXF_STOP;
                end
                S_TXF_STOP: begin
                    if (stop_count_q < STOP_LAST) begin
                        tx_d         = 1'b1;
                        stop_count_d = stop_count_q + 2'd1;
                    end else begin
                        frame_done = 1'b1;
                        if (!fifo_empty) begin
                            // Chain straight into the next start bit.
                            start_frame = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_TXF_IDLE;
                        end
                    end
                end
                default: begin
                    // Recover from an illegal encoding to a safe idle line.
                    tx_d    = 1'b1;
                    state_d = S_TXF_IDLE;
                end
            endcase

            // Latch the head word so later host writes cannot disturb the frame.
            if (start_frame) begin
                shift_d  = fifo_dout;
                parity_d = calc_parity(MAX_DATA_WIDTH'(fifo_dout), PARITY_MODE);
                tx_d     = 1'b0;
                state_d  = S_TXF_START;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_TXF_IDLE;
            shift_q      <= '0;
            bit_count_q  <= '0;
            stop_count_q <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_count_q  <= bit_count_d;
            stop_count_q <= stop_count_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame_controller
//   Four controller instances share clock, reset and baud tick:
//     [0] 8N1  [1] 8E1  [2] 8O1  [3] 7N2, all FIFO_DEPTH 4.
//   Expected line bits are queued when a word is written and popped on each
//   baud tick while the frame is on the line.
// ----------------------------------------------------------------------------
module tb_uart_tx_frame_controller;

    logic       clk;
    logic       rst_n;
    logic       auto_tick, auto_pulse, man_tick;
    wire        tick;
    int         tick_cnt;

    logic [3:0] we_v;
    logic [8:0] wd [4];
    wire  [3:0] line_v, full_v, empty_v, ovf_v, fd_v;

    int         fd_cnt [4];
    logic       exp_q [$];
    int         compared;
    int         mismatched;

    assign tick = auto_pulse | man_tick;

    uart_tx_frame_controller_if #(.DATA_WIDTH(8)) host_8n1 ();
    uart_tx_frame_controller_if #(.DATA_WIDTH(8)) host_8e1 ();
    uart_tx_frame_controller_if #(.DATA_WIDTH(8)) host_8o1 ();
    uart_tx_frame_controller_if #(.DATA_WIDTH(7)) host_7n2 ();

    assign host_8n1.Write_en = we_v[0];  assign host_8n1.Write_data = wd[0][7:0];
    assign host_8e1.Write_en = we_v[1];  assign host_8e1.Write_data = wd[1][7:0];
    assign host_8o1.Write_en = we_v[2];  assign host_8o1.Write_data = wd[2][7:0];
    assign host_7n2.Write_en = we_v[3];  assign host_7n2.Write_data = wd[3][6:0];

    assign full_v  = {host_7n2.Full,       host_8o1.Full,       host_8e1.Full,       host_8n1.Full};
    assign empty_v = {host_7n2.Empty,      host_8o1.Empty,      host_8e1.Empty,      host_8n1.Empty};
    assign ovf_v   = {host_7n2.Overflow,   host_8o1.Overflow,   host_8e1.Overflow,   host_8n1.Overflow};
    assign fd_v    = {host_7n2.Frame_done, host_8o1.Frame_done, host_8e1.Frame_done, host_8n1.Frame_done};

    uart_tx_frame_controller #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .Clock(clk), .Resetn(rst_n), .TX_clock_enable(tick), .host(host_8n1), .UART_TX_O(line_v[0]));
    uart_tx_frame_controller #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .Clock(clk), .Resetn(rst_n), .TX_clock_enable(tick), .host(host_8e1), .UART_TX_O(line_v[1]));
    uart_tx_frame_controller #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .Clock(clk), .Resetn(rst_n), .TX_clock_enable(tick), .host(host_8o1), .UART_TX_O(line_v[2]));
    uart_tx_frame_controller #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .Clock(clk), .Resetn(rst_n), .TX_clock_enable(tick), .host(host_7n2), .UART_TX_O(line_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clock in four, changed 2 time units after the rising edge.
    initial begin
        auto_pulse = 1'b0;
        tick_cnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_tick) begin
                auto_pulse = (tick_cnt == 3);
                tick_cnt   = (tick_cnt + 1) % 4;
            end else begin
                auto_pulse = 1'b0;
                tick_cnt   = 0;
            end
        end
    end

    // Frame_done is combinational with the tick; count it mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (fd_v[i] === 1'b1) fd_cnt[i]++;
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Expected serial frame, built independently from the word.
    function automatic void push_frame(input logic [8:0] d, input int dw, input int pm, input int sb);
        logic par;
        par = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pm != 0) exp_q.push_back((pm == 2) ? ~par : par);
        for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    endfunction

    // Called 2 units after a rising edge; returns 2 units after the write edge.
    task automatic write_word(input int idx, input logic [8:0] d, input logic exp_ovf, input string name);
        we_v[idx] = 1'b1;
        wd[idx]   = d;
        @(negedge clk);
        compared++;
        if (ovf_v[idx] !== exp_ovf) begin
            mismatched++;
            $display("FAIL %s overflow: got %b, expected %b", name, ovf_v[idx], exp_ovf);
        end
        @(posedge clk);
        #2;
        we_v[idx] = 1'b0;
    endtask

    // Pop one expected bit per tick, then require an idle line and Empty.
    task automatic drain(input int idx, input string name);
        logic e;
        logic was;
        int   cyc;
        int   budget;
        budget = 64 + 8 * exp_q.size();
        cyc    = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            was = tick;
            #1;
            if (was) begin
                e = exp_q.pop_front();
                compared++;
                if (line_v[idx] !== e) begin
                    mismatched++;
                    $display("FAIL %s line bit: got %b, expected %b (%0d bits left)", name, line_v[idx], e, exp_q.size());
                end
            end
            cyc++;
            if (cyc > budget && exp_q.size() > 0) begin
                compared++;
                mismatched++;
                $display("FAIL %s timeout: %0d expected bits never appeared", name, exp_q.size());
                exp_q.delete();
            end
        end
        // The tick that ends the last stop bit.
        cyc = 0;
        do begin
            @(posedge clk);
            was = tick;
            cyc++;
        end while (!was && cyc < 64);
        #1;
        compared++;
        if (line_v[idx] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s idle line after frame: got %b, expected 1", name, line_v[idx]);
        end
        compared++;
        if (empty_v[idx] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s empty after last frame: got %b, expected 1", name, empty_v[idx]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            compared += 5;
            if (line_v[i] !== 1'b1) begin mismatched++; $display("FAIL reset line[%0d]: got %b, expected 1", i, line_v[i]); end
            if (empty_v[i] !== 1'b1) begin mismatched++; $display("FAIL reset empty[%0d]: got %b, expected 1", i, empty_v[i]); end
            if (full_v[i] !== 1'b0) begin mismatched++; $display("FAIL reset full[%0d]: got %b, expected 0", i, full_v[i]); end
            if (ovf_v[i] !== 1'b0) begin mismatched++; $display("FAIL reset overflow[%0d]: got %b, expected 0", i, ovf_v[i]); end
            if (fd_v[i] !== 1'b0) begin mismatched++; $display("FAIL reset frame_done[%0d]: got %b, expected 0", i, fd_v[i]); end
        end
    endtask

    task automatic run_single(input int idx, input logic [8:0] d, input int dw, input int pm, input int sb, input string name);
        int fd0;
        sync();
        auto_tick = 1'b1;
        fd0 = fd_cnt[idx];
        push_frame(d, dw, pm, sb);
        write_word(idx, d, 1'b0, name);
        compared++;
        if (empty_v[idx] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s empty after push: got %b, expected 0", name, empty_v[idx]);
        end
        if (idx == 3) wd[3] = 9'h03E;  // host data changes while the frame is queued/on the line
        drain(idx, name);
        compared++;
        if (fd_cnt[idx] - fd0 !== 1) begin
            mismatched++;
            $display("FAIL %s frame_done pulses: got %0d, expected 1", name, fd_cnt[idx] - fd0);
        end
    endtask

    task automatic test_8n1();          run_single(0, 9'h0A5, 8, 0, 1, "8n1");    endtask
    task automatic test_parity();
        run_single(1, 9'h0A5, 8, 1, 1, "8e1");
        run_single(2, 9'h0A5, 8, 2, 1, "8o1");
        run_single(1, 9'h0B5, 8, 1, 1, "8e1_odd_ones");
    endtask
    task automatic test_7n2();          run_single(3, 9'h041, 7, 0, 2, "7n2");    endtask

    task automatic stop_ticks();
        auto_tick = 1'b0;
        sync();
        sync();
    endtask

    task automatic test_depth_overflow();
        logic [8:0] words [5];
        int fd0;
        words[0] = 9'h011; words[1] = 9'h0C3; words[2] = 9'h05A; words[3] = 9'h0F0; words[4] = 9'h099;
        stop_ticks();
        fd0 = fd_cnt[0];
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_frame(words[i], 8, 0, 1);
            write_word(0, words[i], (i == 4), "depth_write");
            compared++;
            if (full_v[0] !== (i >= 3)) begin
                mismatched++;
                $display("FAIL depth full after write %0d: got %b, expected %b", i, full_v[0], (i >= 3));
            end
        end
        auto_tick = 1'b1;
        drain(0, "depth_b2b");
        compared++;
        if (fd_cnt[0] - fd0 !== 4) begin
            mismatched++;
            $display("FAIL depth frame_done pulses: got %0d, expected 4", fd_cnt[0] - fd0);
        end
    endtask

    task automatic test_push_pop_full();
        logic e;
        stop_ticks();
        for (int i = 0; i < 4; i++) begin
            push_frame(9'(8'h21 + 8'(i * 17)), 8, 0, 1);
            write_word(0, 9'(8'h21 + 8'(i * 17)), 1'b0, "pp_fill");
        end
        compared++;
        if (full_v[0] !== 1'b1) begin mismatched++; $display("FAIL pp full before pop: got %b, expected 1", full_v[0]); end
        // Tick (pop) and write in the same cycle while full.
        man_tick  = 1'b1;
        we_v[0]   = 1'b1;
        wd[0]     = 9'h077;
        @(negedge clk);
        compared++;
        if (ovf_v[0] !== 1'b1) begin mismatched++; $display("FAIL pp overflow on pop cycle: got %b, expected 1", ovf_v[0]); end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compared++;
        if (line_v[0] !== e) begin mismatched++; $display("FAIL pp start bit: got %b, expected %b", line_v[0], e); end
        compared++;
        if (full_v[0] !== 1'b0) begin mismatched++; $display("FAIL pp full after pop: got %b, expected 0", full_v[0]); end
        #1;
        man_tick = 1'b0;
        wd[0]    = 9'h03C;
        @(negedge clk);
        compared++;
        if (ovf_v[0] !== 1'b0) begin mismatched++; $display("FAIL pp overflow on refill: got %b, expected 0", ovf_v[0]); end
        @(posedge clk);
        #1;
        compared++;
        if (full_v[0] !== 1'b1) begin mismatched++; $display("FAIL pp full after refill: got %b, expected 1", full_v[0]); end
        #1;
        we_v[0] = 1'b0;
        push_frame(9'h03C, 8, 0, 1);
        auto_tick = 1'b1;
        drain(0, "pp_b2b");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int cyc;
        int fd0;
        logic was;
        sync();
        auto_tick = 1'b1;
        write_word(0, 9'h0A5, 1'b0, "rm_w0");
        write_word(0, 9'h00F, 1'b0, "rm_w1");
        fd0 = fd_cnt[0];
        n   = 0;
        cyc = 0;
        // Pop tick, START tick, first DATA tick: line then carries data bit 1 (0).
        while (n < 3 && cyc < 200) begin
            @(posedge clk);
            if (tick) n++;
            cyc++;
        end
        compared++;
        if (n < 3) begin mismatched++; $display("FAIL rm tick wait timeout: got %0d ticks, expected 3", n); end
        #1;
        compared++;
        if (line_v[0] !== 1'b0) begin mismatched++; $display("FAIL rm line before reset: got %b, expected 0", line_v[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        compared += 3;
        if (line_v[0] !== 1'b1) begin mismatched++; $display("FAIL rm line in reset: got %b, expected 1", line_v[0]); end
        if (empty_v[0] !== 1'b1) begin mismatched++; $display("FAIL rm empty in reset: got %b, expected 1", empty_v[0]); end
        if (full_v[0] !== 1'b0) begin mismatched++; $display("FAIL rm full in reset: got %b, expected 0", full_v[0]); end
        sync();
        rst_n = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 12 && cyc < 200) begin
            @(posedge clk);
            was = tick;
            #1;
            cyc++;
            if (was) begin
                n++;
                compared++;
                if (line_v[0] !== 1'b1 || empty_v[0] !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rm after release tick %0d: line=%b empty=%b, expected line=1 empty=1", n, line_v[0], empty_v[0]);
                end
            end
        end
        compared++;
        if (fd_cnt[0] - fd0 !== 0) begin
            mismatched++;
            $display("FAIL rm frame_done after reset: got %0d pulses, expected 0", fd_cnt[0] - fd0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        auto_tick  = 1'b0;
        man_tick   = 1'b0;
        we_v       = '0;
        for (int i = 0; i < 4; i++) begin
            wd[i]     = '0;
            fd_cnt[i] = 0;
        end
        repeat (3) sync();
        rst_n = 1'b1;
        sync();

        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_depth_overflow();
        test_push_pop_full();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
